// File: rtl/lcd_bus_sequencer.sv
// Owns the HD44780 write bus: arbitrates init vs. application requesters and
// turns each accepted byte into a timed RS/data setup, E pulse, hold and execution wait.
module lcd_bus_sequencer #(
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_E_HIGH    = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 76000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       init_req,
  input  logic       init_rs,
  input  logic [7:0] init_data,
  output logic       init_ack,
  input  logic       app_req,
  input  logic       app_rs,
  input  logic [7:0] app_data,
  output logic       app_ack,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       grant,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Owner is decided from init_done at the moment a byte is accepted.
  logic       sel_req_c;
  logic       sel_rs_c;
  logic [7:0] sel_data_c;
  logic       long_exec_c;
  logic       last_c;

  assign sel_req_c   = init_done ? app_req  : init_req;
  assign sel_rs_c    = init_done ? app_rs   : init_rs;
  assign sel_data_c  = init_done ? app_data : init_data;
  // Clear display / return home need the long execution wait.
  assign long_exec_c = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);
  assign last_c      = (cnt == CNT_W'(1));

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      grant    <= 1'b0;
      busy     <= 1'b0;
      init_ack <= 1'b0;
      app_ack  <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      init_ack <= 1'b0;
      app_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          grant <= init_done;
          if (sel_req_c) begin
            state    <= S_SETUP;
            cnt      <= CNT_W'(T_SETUP);
            busy     <= 1'b1;
            lcd_rs   <= sel_rs_c;
            lcd_data <= sel_data_c;
            init_ack <= !init_done;
            app_ack  <= init_done;
          end
        end
        S_SETUP: begin
          if (last_c) begin
            state <= S_E_HIGH;
            cnt   <= CNT_W'(T_E_HIGH);
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_E_HIGH: begin
          if (last_c) begin
            state <= S_HOLD;
            cnt   <= CNT_W'(T_HOLD);
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (last_c) begin
            state <= S_EXEC;
            cnt   <= long_exec_c ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (last_c) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          lcd_e <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: directed scenarios plus random traffic, every cycle
// compared against a transaction-position model of the write bus.
module tb_lcd_bus_sequencer;

  localparam int unsigned TS  = 2;
  localparam int unsigned TE  = 3;
  localparam int unsigned TH  = 1;
  localparam int unsigned TX  = 5;
  localparam int unsigned TXL = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done, init_req, init_rs, app_req, app_rs;
  logic [7:0] init_data, app_data;
  logic       init_ack, app_ack, lcd_rs, lcd_rw, lcd_e, grant, busy;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_bus_sequencer #(
    .T_SETUP(TS), .T_E_HIGH(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL), .CNT_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .init_req(init_req), .init_rs(init_rs), .init_data(init_data), .init_ack(init_ack),
    .app_req(app_req), .app_rs(app_rs), .app_data(app_data), .app_ack(app_ack),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .grant(grant), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: pos = cycle index within the current transfer (0 = idle).
  int         pos;
  int         total;
  logic       m_grant;
  logic       m_rs;
  logic [7:0] m_data;
  logic [8:0] iq[$];
  logic [8:0] aq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int xfer_len(input logic rs, input logic [7:0] data);
    int ex;
    ex = (!rs && data >= 8'd1 && data <= 8'd3) ? TXL : TX;
    return TS + TE + TH + ex;
  endfunction

  task automatic model_edge();
    if (pos == 0) begin
      m_grant = init_done;
      if (init_done ? app_req : init_req) begin
        m_rs   = init_done ? app_rs : init_rs;
        m_data = init_done ? app_data : init_data;
        total  = xfer_len(m_rs, m_data);
        pos    = 1;
      end
    end else if (pos == total) begin
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic compare_all();
    check("busy",     32'(busy),     32'(pos != 0));
    check("lcd_e",    32'(lcd_e),    32'(pos > TS && pos <= TS + TE));
    check("init_ack", 32'(init_ack), 32'(pos == 1 && !m_grant));
    check("app_ack",  32'(app_ack),  32'(pos == 1 && m_grant));
    check("grant",    32'(grant),    32'(m_grant));
    check("lcd_rs",   32'(lcd_rs),   32'(m_rs));
    check("lcd_data", 32'(lcd_data), 32'(m_data));
    check("lcd_rw",   32'(lcd_rw),   32'(1'b0));
  endtask

  // Requesters present queue heads and retire a byte on its ack.
  task automatic drive();
    if (pos == 1 && !m_grant && iq.size() > 0) void'(iq.pop_front());
    if (pos == 1 && m_grant && aq.size() > 0) void'(aq.pop_front());
    init_req = (iq.size() != 0);
    app_req  = (aq.size() != 0);
    {init_rs, init_data} = init_req ? iq[0] : 9'h000;
    {app_rs, app_data}   = app_req ? aq[0] : 9'h000;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    drive();
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (pos != target && n < 200) begin
      step();
      n++;
    end
    if (pos != target) check("wait_pos_timeout", 32'(pos), 32'(target));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(pos == 0 && (init_done ? aq.size() : iq.size()) == 0) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check("drain_timeout", 32'(pos), 32'(0));
    step();
  endtask

  task automatic measure_busy(input logic [8:0] b, input int exp);
    int cnt = 0;
    int n = 0;
    bit seen = 0;
    iq.push_back(b);
    drive();
    while (n < 200 && !(seen && !busy)) begin
      step();
      if (busy) begin
        cnt++;
        seen = 1;
      end
      n++;
    end
    check("busy_len", 32'(cnt), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    init_done = 1'b0;
    pos = 0; total = 0; m_grant = 1'b0; m_rs = 1'b0; m_data = 8'h00;
    drive();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Typical init command, clear (long wait) and a near-boundary command.
    measure_busy({1'b0, 8'h38}, 11);
    step();
    measure_busy({1'b0, 8'h01}, 26);
    step();
    measure_busy({1'b0, 8'h04}, 11);
    step();
    measure_busy({1'b1, 8'h02}, 11);
    step();

    // Non-granted application request is ignored until hand-over.
    aq.push_back({1'b0, 8'h55});
    drive();
    repeat (50) step();
    init_done = 1'b1;
    wait_drain();

    // Hand-over while an init byte is in its E pulse.
    init_done = 1'b0;
    repeat (2) step();
    iq.push_back({1'b0, 8'h0C});
    aq.push_back({1'b1, 8'h48});
    drive();
    wait_pos(TS + 1);
    init_done = 1'b1;
    wait_drain();

    // Back-to-back application bytes.
    aq.push_back({1'b1, 8'h41});
    aq.push_back({1'b1, 8'h42});
    drive();
    wait_drain();

    // Asynchronous reset in the middle of the E pulse.
    init_done = 1'b0;
    repeat (2) step();
    iq.push_back({1'b0, 8'h38});
    drive();
    wait_pos(TS + 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_lcd_e", 32'(lcd_e), 32'(0));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_data",  32'(lcd_data), 32'(0));
    pos = 0; m_grant = 1'b0; m_rs = 1'b0; m_data = 8'h00;
    iq.delete();
    aq.delete();
    drive();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    repeat (10) step();

    // Random traffic with occasional owner changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [8:0] b;
        b[8]   = 1'($urandom_range(0, 1));
        b[7:0] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          if (iq.size() < 3) iq.push_back(b);
        end else begin
          if (aq.size() < 3) aq.push_back(b);
        end
      end
      if ($urandom_range(0, 149) == 0) init_done = ~init_done;
      drive();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
